// File: rtl/dense_controller_if.sv
// Control bundle between the dense-layer sequencer, the AXIS buffers and
// the dense datapath. slave = controller side, master = environment side.
interface dense_controller_if #(
  parameter int CYC_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic                 inStall;
  logic                 outReady;
  logic                 mulDone;
  logic                 calcDone;
  logic                 putData;
  logic                 clear;
  logic                 clearReg;
  logic                 inCntEn;
  logic                 load;
  logic                 WorB;
  logic                 outCntEn;
  logic                 outWrite;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [CYC_WIDTH-1:0] cycleCount;
  logic [2:0]           state;

  modport slave (
    input  start, abort, inStall, outReady,
    input  mulDone, calcDone, putData,
    output clear, clearReg, inCntEn, load, WorB,
    output outCntEn, outWrite, busy, done, error,
    output cycleCount, state
  );

  modport master (
    output start, abort, inStall, outReady,
    output mulDone, calcDone, putData,
    input  clear, clearReg, inCntEn, load, WorB,
    input  outCntEn, outWrite, busy, done, error,
    input  cycleCount, state
  );
endinterface

// File: rtl/dense_controller.sv
// Dense-layer sequencer: INIT -> (MAC* -> BIAS) per neuron -> DONE.
// Ports: clk, rst (sync, active-high), ctl (dense_controller_if.slave).
module dense_controller #(
  parameter int CYC_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  dense_controller_if.slave ctl
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MAC  = 3'd2,
    S_BIAS = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic                 err_q, err_d;

  logic       clear, clear_reg, in_cnt_en, load;
  logic       worb, out_cnt_en, out_write;
  logic       busy, done, accept;
  logic [2:0] state_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    clear_reg  = 1'b0;
    in_cnt_en  = 1'b0;
    load       = 1'b0;
    worb       = 1'b0;
    out_cnt_en = 1'b0;
    out_write  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    state_o    = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d = S_INIT;
          accept  = 1'b1;
        end
      end
      S_INIT: begin
        busy      = 1'b1;
        clear     = 1'b1;
        clear_reg = 1'b1;
        state_d   = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (!ctl.inStall) begin
          in_cnt_en = 1'b1;
          load      = 1'b1;
          if (ctl.mulDone) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        busy = 1'b1;
        worb = 1'b1;
        if (ctl.outReady) begin
          out_write  = 1'b1;
          out_cnt_en = 1'b1;
          clear_reg  = 1'b1;
          state_d    = ctl.calcDone ? S_DONE : S_MAC;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        state_o = S_IDLE;
      end
    endcase
    // abort beats everything, including a start in IDLE
    if (ctl.abort) begin
      state_d    = S_IDLE;
      accept     = 1'b0;
      clear      = 1'b0;
      clear_reg  = 1'b0;
      in_cnt_en  = 1'b0;
      load       = 1'b0;
      worb       = 1'b0;
      out_cnt_en = 1'b0;
      out_write  = 1'b0;
      done       = 1'b0;
    end
  end

  // reads 0 during INIT, then counts every busy cycle
  always_comb begin
    cyc_d = cyc_q;
    if (accept)
      cyc_d = '0;
    else if (busy && (cyc_q != '1))
      cyc_d = cyc_q + 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = 1'b0;
    else if (out_write && (ctl.calcDone != ctl.putData))
      err_d = 1'b1;
  end

  assign ctl.clear      = clear;
  assign ctl.clearReg   = clear_reg;
  assign ctl.inCntEn    = in_cnt_en;
  assign ctl.load       = load;
  assign ctl.WorB       = worb;
  assign ctl.outCntEn   = out_cnt_en;
  assign ctl.outWrite   = out_write;
  assign ctl.busy       = busy;
  assign ctl.done       = done;
  assign ctl.error      = err_q;
  assign ctl.cycleCount = cyc_q;
  assign ctl.state      = state_o;

endmodule

// File: tb/tb_dense_controller.sv
// Bench for dense_controller with a behavioural datapath model.
// Run vectors are table-driven; expected results go through a queue.
module tb_dense_controller;

  localparam int IN_COUNT  = 4;
  localparam int OUT_COUNT = 3;
  localparam int CW        = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dense_controller_if #(.CYC_WIDTH(CW)) ifc();

  dense_controller #(.CYC_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .ctl(ifc)
  );

  int   in_cnt  = 0;
  int   out_cnt = 0;
  logic force_mis = 1'b0;

  assign ifc.mulDone  = (in_cnt == IN_COUNT - 1);
  assign ifc.calcDone = (out_cnt == OUT_COUNT - 1);
  assign ifc.putData  = ifc.calcDone & ~force_mis;

  always @(posedge clk) begin
    if (ifc.clear) begin
      in_cnt  <= 0;
      out_cnt <= 0;
    end else begin
      if (ifc.inCntEn)
        in_cnt <= (in_cnt == IN_COUNT - 1) ? 0 : in_cnt + 1;
      if (ifc.outCntEn)
        out_cnt <= (out_cnt == OUT_COUNT - 1) ? 0 : out_cnt + 1;
    end
  end

  typedef struct {
    int stall_n;
    int stall_len;
    int bp_n;
    int bp_len;
    int extra;
    int mis;
    int lat;
    int cyc;
    int writes;
    int incs;
    int err;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  int tests = 0;
  int fails = 0;

  int stall_n, stall_left, bp_n, bp_left;
  bit mis_en;
  int writes, incs, viol;
  bit prev_write;

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int sn, int sl, int bn, int bl,
                              int ex, int mi);
    vec_t v;
    v.stall_n   = sn;
    v.stall_len = sl;
    v.bp_n      = bn;
    v.bp_len    = bl;
    v.extra     = ex;
    v.mis       = mi;
    v.lat       = 2 + OUT_COUNT * (IN_COUNT + 1) + sl + bl;
    v.cyc       = v.lat - 1;
    v.writes    = OUT_COUNT;
    v.incs      = OUT_COUNT * IN_COUNT;
    v.err       = mi;
    return v;
  endfunction

  // one cycle: drive at negedge, sample 1 time unit later
  task automatic cyc(input bit st, input bit ab);
    @(negedge clk);
    ifc.start   = st;
    ifc.abort   = ab;
    ifc.inStall = (stall_left > 0) && (ifc.state == 3'd2) &&
                  (out_cnt == stall_n) && (in_cnt == 1);
    if (ifc.inStall) stall_left--;
    ifc.outReady = !((bp_left > 0) && (ifc.state == 3'd3) &&
                     (out_cnt == bp_n));
    if (!ifc.outReady) bp_left--;
    force_mis = mis_en && ifc.calcDone;
    #1;
    if (ifc.inStall && (ifc.inCntEn || ifc.load)) viol++;
    if (!ifc.outReady && ifc.outWrite) viol++;
    if (ifc.outWrite && prev_write) viol++;
    prev_write = ifc.outWrite;
    if (ifc.outWrite) writes++;
    if (ifc.inCntEn) incs++;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    bit   got;
    int   lat, cc, er, bz;
    stall_n    = v.stall_n;
    stall_left = v.stall_len;
    bp_n       = v.bp_n;
    bp_left    = v.bp_len;
    mis_en     = (v.mis != 0);
    writes     = 0;
    incs       = 0;
    viol       = 0;
    prev_write = 1'b0;
    got = 1'b0; lat = 0; cc = 0; er = 0; bz = 0;
    sb.push_back(v);
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 200 && !got; k++) begin
      cyc(((k % 5) == 0) && ((k / 5) <= v.extra), 1'b0);
      if (ifc.done) begin
        got = 1'b1;
        lat = k;
        cc  = int'(ifc.cycleCount);
        er  = int'(ifc.error);
        bz  = int'(ifc.busy);
      end
    end
    e = sb.pop_front();
    check("done_seen", got, 1);
    if (got) begin
      check("latency", lat, e.lat);
      check("cycleCount_at_done", cc, e.cyc);
      check("busy_at_done", bz, 1);
      check("outWrite_count", writes, e.writes);
      check("inCntEn_count", incs, e.incs);
      check("error_at_done", er, e.err);
      check("protocol_violations", viol, 0);
    end
    cyc(1'b0, 1'b0);
    check("busy_after_done", ifc.busy, 0);
    check("state_after_done", ifc.state, 0);
    check("done_one_cycle", ifc.done, 0);
    mis_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW+10:0] nz;
    bit found;
    int dn;

    vecs[0] = mk(0, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 2, 2, 3, 0, 0);
    vecs[2] = mk(0, 1, 0, 1, 0, 0);
    vecs[3] = mk(0, 0, 0, 0, 3, 0);
    vecs[4] = mk(0, 0, 0, 0, 0, 1);

    ifc.start    = 1'b0;
    ifc.abort    = 1'b0;
    ifc.inStall  = 1'b0;
    ifc.outReady = 1'b1;
    stall_left = 0;
    bp_left    = 0;
    mis_en     = 1'b0;

    rst = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("rst_state", ifc.state, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_cycleCount", ifc.cycleCount, 0);
    check("rst_error", ifc.error, 0);
    rst = 1'b0;

    nz = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      nz |= {ifc.clear, ifc.clearReg, ifc.inCntEn, ifc.load,
             ifc.WorB, ifc.outCntEn, ifc.outWrite, ifc.busy,
             ifc.done, ifc.error, ifc.state, ifc.cycleCount};
    end
    check("idle_outputs_zero", nz, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    check("error_sticky", ifc.error, 1);
    run_vec(vecs[0]);

    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    check("start_abort_idle_state", ifc.state, 0);
    check("start_abort_idle_busy", ifc.busy, 0);

    cyc(1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      cyc(1'b0, 1'b0);
      if (ifc.state == 3'd2 && out_cnt == 1 && in_cnt == 0)
        found = 1'b1;
    end
    check("abort_reached_mac1", found, 1);
    cyc(1'b0, 1'b1);
    check("abort_cycle_strobes",
          {ifc.clear, ifc.clearReg, ifc.inCntEn, ifc.load,
           ifc.outCntEn, ifc.outWrite, ifc.done}, 0);
    cyc(1'b0, 1'b0);
    check("abort_state", ifc.state, 0);
    check("abort_busy", ifc.busy, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (ifc.done) dn++;
    end
    check("abort_no_done", dn, 0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
